path_uart_reporter: RTL and testbench
=====================================

// Module: path_uart_reporter
// PURPOSE
//  Downstream reporter for the GA loop: when the State controller pulses its uart_transmit
//  line, this block latches one 150-bit path and streams it on uart_out as a framed 8N1 packet.
//  The latched path is the fittest path of the current generation.
//  It replaces the constant-0 uart_out tie-off in the top level.
//  Frame: SYNC, generation count, path payload bytes, XOR checksum.
// PARAMETERS
//  CLKS_PER_BIT  868    clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  PATH_BITS     150    width of path_in; NUM_BYTES = (PATH_BITS+7)/8 = 19 payload bytes
//  SYNC_BYTE     8'hA5  first byte of every frame
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst_n      in   1          asynchronous active-low reset
//  start      in   1          1-cycle request pulse (driven from State uart_transmit)
//  path_in    in   PATH_BITS  path to report; sampled only on an accepted start
//  busy       out  1          high while a frame is in flight
//  done       out  1          1-cycle pulse when the last stop bit completes
//  uart_out   out  1          serial TX line, idle high
// BEHAVIOUR
//  Reset (async, rst_n=0): uart_out=1, busy=0, done=0, FSM=IDLE, bit/byte/baud counters=0.
//    Reset also clears gen_cnt (8b) to 0 and clears the checksum accumulator.
//  Reset mid-frame aborts the frame. uart_out goes high without waiting for a clock edge.
//    No done pulse is produced. The next frame after reset carries gen=0x00.
//  Accept: start=1 while busy=0 at edge t.
//    path_in is latched into a shift buffer, zero-padded on the MSB side up to NUM_BYTES*8 bits.
//    From t+1: busy=1 and uart_out=0 (start bit of SYNC).
//  start while busy=1 is ignored. No queueing, no effect on the current frame.
//  path_in changes after the accept edge have no effect on the frame.
//  Byte order: SYNC_BYTE, gen_cnt, payload[0..NUM_BYTES-1], CHK. Total NUM_BYTES+3 bytes (22).
//    payload[k] = padded_path[8k+7:8k], so path bit 0 goes out first overall.
//  Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//    Each bit is held exactly CLKS_PER_BIT cycles.
//    No idle gap between bytes: a stop bit is followed directly by the next start bit.
//  CHK = gen_cnt ^ payload[0] ^ ... ^ payload[NUM_BYTES-1]. SYNC_BYTE is excluded from CHK.
//  FSM states and transitions:
//    IDLE  -> START on an accepted start.
//    START -> DATA after 1 bit period.
//    DATA  -> STOP after 8 bit periods.
//    STOP  -> START if more bytes remain; after the CHK byte, STOP -> DONE.
//    DONE lasts 1 cycle: done=1, busy=0, uart_out=1. DONE -> IDLE.
//  Cycle timing: DONE is the cycle at t+1+(NUM_BYTES+3)*10*CLKS_PER_BIT.
//    With the default PATH_BITS this is t+1+220*CLKS_PER_BIT.
//  gen_cnt increments by 1 in the DONE cycle and wraps 0xFF -> 0x00. Aborted frames do not increment it.
//  start in the DONE cycle is accepted: busy=0 there, and the new frame begins next cycle.
//    That new frame carries the already-incremented gen_cnt.
//  Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
//    The byte index counter width is $clog2(NUM_BYTES+3).
//  PATH_BITS a multiple of 8: no padding. The arithmetic above is unchanged.
// TESTING  (bench uses CLKS_PER_BIT=4, PATH_BITS=150; one frame = 880 cycles)
//  1. Assert rst_n=0 for 3 cycles, then release
//     -> uart_out=1, busy=0, done=0; all three hold for 50 idle cycles.
//  2. path_in=0, start pulse at t
//     -> decoded bytes A5,00, then 19x00, then CHK 00.
//     -> busy high for cycles t+1..t+880; done pulses at t+881; uart_out low at t+1.
//  3. Second frame with path_in[7:0]=8'h3C, rest 0
//     -> bytes A5,01,3C, then 18x00, then CHK 3D.
//     -> path_in[149:144]=6'h3F alone (frame gen=02) gives payload[18]=8'h3F (padding 0).
//  4. Pulse start at t+100 and t+500 of an active frame, and change path_in at t+2
//     -> frame identical to case 2; only one done pulse.
//  5. rst_n=0 asynchronously mid-frame, while a data bit is low
//     -> uart_out=1 before the next clk edge; no done pulse.
//     -> the next frame carries gen=00.
//  6. 256 back-to-back frames, each start issued in the DONE cycle of the previous frame
//     -> gen bytes 00..FF, then 00; no idle bit between frames.
//     -> every CHK matches the XOR rule.

Source files
------------

// File: rtl/path_uart_reporter.sv
// Serialises one latched GA path as an 8N1 frame: SYNC, generation count,
// path payload bytes (LSB byte first), XOR checksum over gen and payload.
module path_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PATH_BITS    = 150,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PATH_BITS-1:0] path_in,
    output logic                 busy,
    output logic                 done,
    output logic                 uart_out
);

    localparam int unsigned NUM_BYTES = (PATH_BITS + 7) / 8;
    localparam int unsigned BUF_W     = NUM_BYTES * 8;
    localparam int unsigned NUM_FRAME = NUM_BYTES + 3;
    localparam int unsigned LAST_BYTE = NUM_FRAME - 1;
    localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W    = $clog2(NUM_FRAME);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [7:0]          gen_q, gen_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          sh_q, sh_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic                uart_q, uart_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_end;
    logic [BYTE_W-1:0]   nxt_idx;
    logic [7:0]          nxt_byte;
    logic                nxt_is_chk;

    assign busy     = busy_q;
    assign done     = done_q;
    assign uart_out = uart_q;

    // Byte that follows the current one: gen, then payload from the buffer, then checksum
    always_comb begin
        bit_end    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        nxt_idx    = byte_q + BYTE_W'(1);
        nxt_is_chk = (nxt_idx == BYTE_W'(LAST_BYTE));
        if (nxt_idx == BYTE_W'(1)) begin
            nxt_byte = gen_q;
        end else if (nxt_is_chk) begin
            nxt_byte = chk_q;
        end else begin
            nxt_byte = buf_q[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gen_d   = gen_q;
        chk_d   = chk_q;
        sh_d    = sh_q;
        buf_d   = buf_q;
        uart_d  = uart_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE && state_q != DONE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                uart_d  = 1'b1;
                busy_d  = 1'b0;
                if (start) begin
                    buf_d                  = '0;
                    buf_d[PATH_BITS-1:0]   = path_in;
                    state_d                = START;
                    baud_d                 = '0;
                    byte_d                 = '0;
                    chk_d                  = '0;
                    sh_d                   = SYNC_BYTE;
                    uart_d                 = 1'b0;
                    busy_d                 = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    uart_d  = sh_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        uart_d  = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        uart_d = sh_q[1];
                        sh_d   = {1'b0, sh_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == BYTE_W'(LAST_BYTE)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        uart_d  = 1'b1;
                        gen_d   = gen_q + 8'd1;
                    end else begin
                        state_d = START;
                        byte_d  = nxt_idx;
                        sh_d    = nxt_byte;
                        uart_d  = 1'b0;
                        if (!nxt_is_chk) begin
                            chk_d = chk_q ^ nxt_byte;
                        end
                        if (!nxt_is_chk && nxt_idx != BYTE_W'(1)) begin
                            buf_d = buf_q >> 8;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces the line idle immediately and discards any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            gen_q   <= '0;
            chk_q   <= '0;
            sh_q    <= '0;
            buf_q   <= '0;
            uart_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gen_q   <= gen_d;
            chk_q   <= chk_d;
            sh_q    <= sh_d;
            buf_q   <= buf_d;
            uart_q  <= uart_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_path_uart_reporter.sv
// Bench for path_uart_reporter: a 150-bit instance (4 clk/bit) for framing,
// payload, ignore and reset cases, and an 8-bit instance (2 clk/bit) for gen wrap.
module tb_path_uart_reporter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_a, start_b;
    logic [149:0] path_a;
    logic [7:0]   path_b;
    logic         busy_a, done_a, uart_a;
    logic         busy_b, done_b, uart_b;

    always #5 clk = ~clk;

    path_uart_reporter #(.CLKS_PER_BIT(4), .PATH_BITS(150), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .path_in(path_a),
        .busy(busy_a), .done(done_a), .uart_out(uart_a));

    path_uart_reporter #(.CLKS_PER_BIT(2), .PATH_BITS(8), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .path_in(path_b),
        .busy(busy_b), .done(done_b), .uart_out(uart_b));

    int         checks = 0;
    int         errors = 0;
    logic [7:0] gen_a, gen_b;

    typedef struct {
        logic [149:0] path;
        int           gen;
        int           chk;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference frame: byte list built from the framing rules, byte idx 0..nb+2
    function automatic logic [7:0] model_byte(input int nb, input logic [151:0] pp,
                                              input logic [7:0] gen, input int idx);
        logic [7:0] x;
        if (idx == 0) return 8'hA5;
        if (idx == 1) return gen;
        if (idx <= nb + 1) return pp[8*(idx-2) +: 8];
        x = gen;
        for (int k = 0; k < nb; k++) x = x ^ pp[8*k +: 8];
        return x;
    endfunction

    task automatic run_frame(input bit sel, input logic [149:0] p, input bit chain,
                             input bit disturb, input int tgen, input int tchk, input string tag);
        int           nb, cpb, len, bad, mism, idx, pos;
        logic [151:0] pp;
        logic [7:0]   g, b, dec;
        logic         got [0:879];
        logic         exp_bit;
        nb  = sel ? 1 : 19;
        cpb = sel ? 2 : 4;
        len = (nb + 3) * 10 * cpb;
        pp  = sel ? {144'b0, p[7:0]} : {2'b00, p};
        g   = sel ? gen_b : gen_a;
        if (sel) begin path_b = p[7:0]; start_b = 1'b1; end
        else     begin path_a = p;      start_a = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        bad = 0;
        for (int c = 1; c <= len; c++) begin
            got[c-1] = sel ? uart_b : uart_a;
            if ((sel ? busy_b : busy_a) !== 1'b1 || (sel ? done_b : done_a) !== 1'b0) bad++;
            if (disturb && c == 2) path_a = ~path_a;
            start_a = disturb && (c == 100 || c == 500);
            @(negedge clk);
        end
        check({tag, "_busy_in_frame"}, 32'(bad), 32'd0);
        check({tag, "_done_busy_uart"},
              32'(sel ? {done_b, busy_b, uart_b} : {done_a, busy_a, uart_a}), 32'b101);
        mism = 0;
        for (int i = 0; i < len; i++) begin
            idx = i / cpb;
            pos = idx % 10;
            b   = model_byte(nb, pp, g, idx / 10);
            exp_bit = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : b[pos-1];
            if (got[i] !== exp_bit) mism++;
        end
        check({tag, "_wave_mismatches"}, 32'(mism), 32'd0);
        if (tgen >= 0) begin
            for (int k = 0; k < 8; k++) dec[k] = got[(10 + 1 + k) * cpb + cpb / 2];
            check({tag, "_gen_byte"}, 32'(dec), 32'(tgen));
        end
        if (tchk >= 0) begin
            for (int k = 0; k < 8; k++) dec[k] = got[((nb + 2) * 10 + 1 + k) * cpb + cpb / 2];
            check({tag, "_chk_byte"}, 32'(dec), 32'(tchk));
        end
        if (sel) gen_b = gen_b + 8'd1;
        else     gen_a = gen_a + 8'd1;
        if (!chain) repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t         tbl [3];
        logic [159:0] rnd;
        int           bad;

        tbl[0] = '{150'h0, 0, 8'h00};
        tbl[1] = '{150'h3C, 1, 8'h3D};
        tbl[2] = '{{6'h3F, 144'h0}, 2, 8'h3D};

        gen_a = 8'h00;
        gen_b = 8'h00;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        path_a = '0;
        path_b = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({done_a, busy_a, uart_a}), 32'b001);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if ({done_a, busy_a, uart_a} !== 3'b001 || {done_b, busy_b, uart_b} !== 3'b001) bad++;
            @(negedge clk);
        end
        check("idle_50_cycles", 32'(bad), 32'd0);

        for (int i = 0; i < 3; i++) run_frame(1'b0, tbl[i].path, 1'b0, 1'b0, tbl[i].gen, tbl[i].chk, "table");

        run_frame(1'b0, 150'h0, 1'b0, 1'b1, 3, 8'h03, "ignore_start");

        for (int r = 0; r < 4; r++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            run_frame(1'b0, rnd[149:0], r < 3, 1'b0, 4 + r, -1, "random");
        end

        // Abort mid-frame on a low data bit (payload byte 3, bit 2 of an all-zero path)
        path_a = '0;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (212) @(negedge clk);
        check("abort_data_bit_low", 32'(uart_a), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_async_uart_busy", 32'({busy_a, uart_a}), 32'b01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gen_a = 8'h00;
        gen_b = 8'h00;
        bad = 0;
        for (int c = 0; c < 900; c++) begin
            if (done_a !== 1'b0) bad++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(bad), 32'd0);
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        run_frame(1'b0, rnd[149:0], 1'b0, 1'b0, 0, -1, "post_reset");

        for (int i = 0; i <= 256; i++) begin
            run_frame(1'b1, 150'($urandom), i < 256, 1'b0, i % 256, -1, "back_to_back");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
